// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch IF/ID flush,
// HALT drain, debug freeze and a saturating load-use stall counter.
module hazard_control_unit #(
   parameter int unsigned N_REG          = 32,
   parameter int unsigned _NB_INDEX_REG  = $clog2(N_REG),
   parameter int unsigned NB_STALL_COUNT = 16,
   parameter int unsigned DRAIN_CYCLES   = 4
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_exe_memread,
   input  logic [_NB_INDEX_REG-1:0]  i_exe_regdest,
   input  logic [_NB_INDEX_REG-1:0]  i_dec_indexRS,
   input  logic [_NB_INDEX_REG-1:0]  i_dec_indexRT,
   input  logic                      i_dec_uses_rt,
   input  logic                      i_dec_branch_taken,
   input  logic                      i_dec_halt,
   output logic                      o_pc_write,
   output logic                      o_ifid_write,
   output logic                      o_ifid_flush,
   output logic                      o_idex_bubble,
   output logic                      o_halted,
   output logic [NB_STALL_COUNT-1:0] o_stall_count
);

   // A single-cycle drain still needs a one-bit counter.
   localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [NB_DRAIN-1:0]       drain_cnt;
   logic [NB_DRAIN-1:0]       drain_cnt_next;
   logic [NB_STALL_COUNT-1:0] stall_count;
   logic [NB_STALL_COUNT-1:0] stall_count_next;
   logic                      load_use;

   // Load in EX feeds a source of the ID instruction; r0 is never a real dependency.
   assign load_use = i_exe_memread & (i_exe_regdest != '0) &
                     ((i_dec_indexRS == i_exe_regdest) |
                      (i_dec_uses_rt & (i_dec_indexRT == i_exe_regdest)));

   assign o_stall_count = stall_count;

   // State, drain counter and stall counter registers with synchronous reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state       <= RUN;
         drain_cnt   <= '0;
         stall_count <= '0;
      end else begin
         state       <= state_next;
         drain_cnt   <= drain_cnt_next;
         stall_count <= stall_count_next;
      end
   end

   // Next-state and pipeline control outputs; freeze and reset override the FSM.
   always_comb begin
      state_next       = state;
      drain_cnt_next   = drain_cnt;
      stall_count_next = stall_count;
      o_pc_write       = 1'b0;
      o_ifid_write     = 1'b0;
      o_ifid_flush     = 1'b0;
      o_idex_bubble    = 1'b0;
      o_halted         = (state == HALTED);

      if (!i_reset) begin
         o_idex_bubble = 1'b1;
         o_halted      = 1'b0;
      end else if (i_enable) begin
         case (state)
            RUN: begin
               if (load_use) begin
                  o_idex_bubble = 1'b1;
                  if (stall_count != '1)
                     stall_count_next = stall_count + NB_STALL_COUNT'(1);
               end else if (i_dec_branch_taken) begin
                  o_pc_write   = 1'b1;
                  o_ifid_write = 1'b1;
                  o_ifid_flush = 1'b1;
               end else if (i_dec_halt) begin
                  state_next     = DRAIN;
                  drain_cnt_next = NB_DRAIN'(DRAIN_CYCLES - 1);
               end else begin
                  o_pc_write   = 1'b1;
                  o_ifid_write = 1'b1;
               end
            end
            DRAIN: begin
               o_idex_bubble = 1'b1;
               if (drain_cnt == '0)
                  state_next = HALTED;
               else
                  drain_cnt_next = drain_cnt - NB_DRAIN'(1);
            end
            HALTED: begin
               o_idex_bubble = 1'b1;
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed vectors push expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_control_unit;

   localparam logic [4:0] O_RUN   = 5'b11000; // {pc_write, ifid_write, flush, bubble, halted}
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_BR    = 5'b11100;
   localparam logic [4:0] O_HALT  = 5'b00000;
   localparam logic [4:0] O_DRAIN = 5'b00010;
   localparam logic [4:0] O_HLTD  = 5'b00011;
   localparam logic [4:0] O_FRZ   = 5'b00000;
   localparam logic [4:0] O_FRZH  = 5'b00001;
   localparam logic [4:0] O_RST   = 5'b00010;

   typedef struct {
      logic [4:0]  outs;
      logic [15:0] cnt;
      logic [1:0]  sat;
      int          id;
   } exp_t;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_exe_memread = 1'b0;
   logic [4:0]  i_exe_regdest = '0;
   logic [4:0]  i_dec_indexRS = '0;
   logic [4:0]  i_dec_indexRT = '0;
   logic        i_dec_uses_rt = 1'b0;
   logic        i_dec_branch_taken = 1'b0;
   logic        i_dec_halt = 1'b0;

   logic        o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_halted;
   logic [15:0] o_stall_count;
   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_halted;
   logic [1:0]  s_stall_count;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   vec_id = 0;
   logic [15:0] exp_cnt = '0;
   logic [1:0]  exp_sat = '0;

   always #5 i_clock = ~i_clock;

   hazard_control_unit #(.DRAIN_CYCLES(4)) u_dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
      .i_exe_memread(i_exe_memread), .i_exe_regdest(i_exe_regdest),
      .i_dec_indexRS(i_dec_indexRS), .i_dec_indexRT(i_dec_indexRT),
      .i_dec_uses_rt(i_dec_uses_rt), .i_dec_branch_taken(i_dec_branch_taken),
      .i_dec_halt(i_dec_halt),
      .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_ifid_flush(o_ifid_flush),
      .o_idex_bubble(o_idex_bubble), .o_halted(o_halted), .o_stall_count(o_stall_count)
   );

   hazard_control_unit #(.NB_STALL_COUNT(2), .DRAIN_CYCLES(4)) u_sat (
      .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
      .i_exe_memread(i_exe_memread), .i_exe_regdest(i_exe_regdest),
      .i_dec_indexRS(i_dec_indexRS), .i_dec_indexRT(i_dec_indexRT),
      .i_dec_uses_rt(i_dec_uses_rt), .i_dec_branch_taken(i_dec_branch_taken),
      .i_dec_halt(i_dec_halt),
      .o_pc_write(s_pc_write), .o_ifid_write(s_ifid_write), .o_ifid_flush(s_ifid_flush),
      .o_idex_bubble(s_idex_bubble), .o_halted(s_halted), .o_stall_count(s_stall_count)
   );

   // Drive one cycle of inputs, queue the hand-computed expectation, advance one edge.
   task automatic step(input logic rst_n, input logic en, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic hl, input logic [4:0] outs, input logic stall);
      exp_t e;
      i_reset = rst_n; i_enable = en; i_exe_memread = mr; i_exe_regdest = rd;
      i_dec_indexRS = rs; i_dec_indexRT = rt; i_dec_uses_rt = urt;
      i_dec_branch_taken = br; i_dec_halt = hl;
      e.outs = outs; e.cnt = exp_cnt; e.sat = exp_sat; e.id = vec_id;
      sb.push_back(e);
      vec_id++;
      @(posedge i_clock);
      #1;
      if (!rst_n) begin
         exp_cnt = '0;
         exp_sat = '0;
      end else if (stall) begin
         exp_cnt = exp_cnt + 16'd1;
         if (exp_sat != 2'b11) exp_sat = exp_sat + 2'd1;
      end
   endtask

   // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
   initial begin
      exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge i_clock);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            act = {o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble, o_halted};
            n_cmp++;
            if (act !== e.outs || o_stall_count !== e.cnt || s_stall_count !== e.sat) begin
               n_bad++;
               $display("FAIL vec%0d: got outs=%b cnt=%0d sat=%0d, required outs=%b cnt=%0d sat=%0d",
                        e.id, act, o_stall_count, s_stall_count, e.outs, e.cnt, e.sat);
            end
         end
      end
   end

   initial begin
      @(posedge i_clock); #1;
      // reset held two cycles, then free-running
      step(0,1,0,0,0,0,0,0,0, O_RST, 0);
      step(0,1,0,0,0,0,0,0,0, O_RST, 0);
      step(1,1,0,0,0,0,0,0,0, O_RUN, 0);
      // load-use on RS, then count visible
      step(1,1,1,5,5,0,0,0,0, O_STALL, 1);
      step(1,1,0,0,0,0,0,0,0, O_RUN, 0);
      // RT match without uses_rt, and r0 destination: no stall
      step(1,1,1,5,3,5,0,0,0, O_RUN, 0);
      step(1,1,1,0,0,0,1,0,0, O_RUN, 0);
      // RT match with uses_rt
      step(1,1,1,5,3,5,1,0,0, O_STALL, 1);
      // freeze in RUN with a load-use present: nothing counts
      step(1,0,1,5,5,0,0,1,0, O_FRZ, 0);
      // branch alone, branch under stall, branch re-evaluated
      step(1,1,0,0,0,0,0,1,0, O_BR, 0);
      step(1,1,1,7,7,0,0,1,0, O_STALL, 1);
      step(1,1,0,0,0,0,0,1,0, O_BR, 0);
      // branch beats halt
      step(1,1,0,0,0,0,0,1,1, O_BR, 0);
      // two more stalls: narrow counter saturates at 3
      step(1,1,1,9,9,0,0,0,0, O_STALL, 1);
      step(1,1,1,9,0,9,1,0,0, O_STALL, 1);
      step(1,1,0,0,0,0,0,0,0, O_RUN, 0);
      // halt decode, then drain with a freeze in the middle
      step(1,1,0,0,0,0,0,0,1, O_HALT, 0);
      step(1,1,0,0,0,0,0,0,0, O_DRAIN, 0);
      step(1,0,1,4,4,0,0,1,0, O_FRZ, 0);
      step(1,0,0,0,0,0,0,0,1, O_FRZ, 0);
      step(1,0,0,0,0,0,0,1,0, O_FRZ, 0);
      step(1,1,1,4,4,0,0,0,0, O_DRAIN, 0);
      step(1,1,0,0,0,0,0,1,0, O_DRAIN, 0);
      step(1,1,0,0,0,0,0,0,1, O_DRAIN, 0);
      // halted: hazards ignored, freeze keeps o_halted
      step(1,1,1,6,6,0,0,1,0, O_HLTD, 0);
      step(1,1,0,0,0,0,0,0,1, O_HLTD, 0);
      step(1,0,0,0,0,0,0,0,0, O_FRZH, 0);
      step(1,1,0,0,0,0,0,0,0, O_HLTD, 0);
      // reset out of HALTED, RUN resumes with cleared counters
      step(0,1,0,0,0,0,0,0,0, O_RST, 0);
      step(1,1,0,0,0,0,0,0,0, O_RUN, 0);
      step(1,1,1,8,8,0,0,0,0, O_STALL, 1);
      step(1,1,0,0,0,0,0,0,0, O_RUN, 0);
      // drain queue with a bound
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge i_clock);
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It works alongside the forwarding unit and handles the hazards that forwarding cannot resolve:
- load-use stalls,
- taken-branch IF/ID flush,
- HALT drain.
It drives PC write-enable, IF/ID write/flush and ID/EX bubble insertion, keeps a saturating stall counter for the debug unit, and freezes when the debug unit deasserts enable.

Parameters:
N_REG, 32, register file size.
_NB_INDEX_REG, $clog2(N_REG), register index width.
NB_STALL_COUNT, 16, width of stall counter.
DRAIN_CYCLES, 4, cycles spent in DRAIN after HALT decode (ID/EX..WB), must be >=1.

Ports:
i_clock  in  1  system clock, all state updates on rising edge.
i_reset  in  1  synchronous reset, active-low.
i_enable  in  1  pipeline step enable from debug unit; 0 = freeze.
i_exe_memread  in  1  instruction in EX is a load.
i_exe_regdest  in  _NB_INDEX_REG  destination register of instruction in EX.
i_dec_indexRS  in  _NB_INDEX_REG  RS of instruction in ID.
i_dec_indexRT  in  _NB_INDEX_REG  RT of instruction in ID.
i_dec_uses_rt  in  1  ID instruction reads RT as a source.
i_dec_branch_taken  in  1  branch/jump resolved taken in ID this cycle.
i_dec_halt  in  1  ID instruction is HALT.
o_pc_write  out  1  PC register write-enable.
o_ifid_write  out  1  IF/ID register write-enable.
o_ifid_flush  out  1  load NOP into IF/ID on next edge.
o_idex_bubble  out  1  zero ID/EX control (inject NOP).
o_halted  out  1  pipeline drained and stopped.
o_stall_count  out  NB_STALL_COUNT  number of load-use stall cycles since reset.

Behaviour:
- The clock is i_clock. Reset is i_reset, synchronous and active-low: it is sampled only on the rising edge of i_clock and takes effect while i_reset is 0.
- Reset (i_reset=0 at the edge):
  - state=RUN, drain counter=0, o_stall_count=0.
  - While in reset, outputs are forced: o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=1, o_halted=0.
  - Reset mid-DRAIN or in HALTED returns to RUN.
- Hazard term, combinational:
  - load_use = i_exe_memread & (i_exe_regdest != 0) & ((i_dec_indexRS == i_exe_regdest) | (i_dec_uses_rt & (i_dec_indexRT == i_exe_regdest))).
  - Register 0 never causes a stall.
- Outputs are combinational from state and inputs, with zero latency: a hazard seen in cycle N gates the edge ending cycle N.
- FSM states: RUN, DRAIN, HALTED. Priority in RUN is load_use > branch_taken > halt.
- RUN, load_use=1:
  - o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=1.
  - o_stall_count increments, saturating at all-ones.
  - State stays RUN. Exactly one bubble per load; the next cycle the load is in MEM and forwarding covers it.
- RUN, branch_taken=1 (no load_use):
  - o_pc_write=1, o_ifid_write=1, o_ifid_flush=1, o_idex_bubble=0. State stays RUN.
  - If load_use and branch_taken are both set, the stall wins, no flush occurs, and the branch is re-evaluated next cycle.
- RUN, halt=1 (no load_use, no branch):
  - o_pc_write=0, o_ifid_write=0, o_idex_bubble=0, so HALT passes into ID/EX.
  - Next state is DRAIN; drain counter loads DRAIN_CYCLES-1.
- RUN, otherwise: o_pc_write=1, o_ifid_write=1, o_ifid_flush=0, o_idex_bubble=0.
- DRAIN:
  - o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=1.
  - The counter decrements each enabled cycle. When the counter is 0, next state is HALTED.
  - load_use, branch and halt inputs are ignored.
- HALTED:
  - o_halted=1, o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=1.
  - Exit only by reset.
- i_enable=0, in any state:
  - o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_idex_bubble=0.
  - State, drain counter and o_stall_count hold.
  - o_halted still reflects state (=1 in HALTED).
- o_halted and o_stall_count are registered/state-derived and glitch-free.

Test Plan:
1. Reset: hold i_reset=0 for 2 cycles, then release -> during reset o_pc_write=0, o_idex_bubble=1, o_stall_count=0; after release, with no hazards, o_pc_write=1, o_ifid_write=1.
2. Load-use: exe_memread=1, exe_regdest=5, dec_RS=5 for one cycle -> that cycle o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; o_stall_count=1 next cycle. Same with dec_RT=5 and uses_rt=0 -> no stall. Same with regdest=0 -> no stall.
3. Branch vs stall: branch_taken=1 alone -> o_ifid_flush=1, o_pc_write=1. branch_taken=1 with load_use=1 -> o_ifid_flush=0, bubble=1; next cycle (load_use=0, branch_taken=1) -> flush=1.
4. Halt drain, DRAIN_CYCLES=4: dec_halt=1 at cycle 0 -> DRAIN in cycles 1-4 (bubble=1, pc_write=0); o_halted=1 from cycle 5 onward; further load_use/branch has no effect.
5. Freeze: i_enable=0 during DRAIN for 3 cycles -> all write/flush/bubble outputs 0, counter holds; o_halted still asserts exactly 4 enabled cycles after HALT.
6. Saturation/reset mid-op: NB_STALL_COUNT=2, 5 stalls -> o_stall_count=3. Reset in HALTED -> o_halted=0, RUN resumes.
